// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-pattern generator.
// Contents: chan_cfg_t (div/high/phase), reset defaults, write legality check,
// channel-select width helper.
package clk_gen_pkg;

  localparam int unsigned CFG_W      = 8;
  localparam int unsigned DFLT_DIV   = 4;
  localparam int unsigned DFLT_HIGH  = 2;
  localparam int unsigned DFLT_PHASE = 0;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  // Build a channel config from integer fields (used for reset defaults).
  function automatic chan_cfg_t make_cfg(int unsigned div, int unsigned high,
                                         int unsigned phase);
    chan_cfg_t c;
    c.div   = CFG_W'(div);
    c.high  = CFG_W'(high);
    c.phase = CFG_W'(phase);
    return c;
  endfunction

  // A config is usable iff div >= 2, 1 <= high < div and phase < div.
  function automatic logic cfg_legal(chan_cfg_t cfg);
    return (cfg.div >= CFG_W'(2)) && (cfg.high != '0) &&
           (cfg.high < cfg.div) && (cfg.phase < cfg.div);
  endfunction

  // Channel-select width; at least one bit even for a single channel.
  function automatic int unsigned ch_width(int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Configuration/status bundle for clk_gen_multi.
// Inputs (to DUT): i_cfg_we, i_cfg_ch, i_cfg_div, i_cfg_high, i_cfg_phase.
// Outputs (from DUT): o_cfg_err, o_clk[CHANNELS], o_locked,
// and o_ce[CHANNELS] when CLKGEN_CE_EN is defined.
interface clk_gen_multi_if
  import clk_gen_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = CFG_W
);
  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic                i_cfg_we;
  logic [CH_W-1:0]     i_cfg_ch;
  logic [CNT_W-1:0]    i_cfg_div;
  logic [CNT_W-1:0]    i_cfg_high;
  logic [CNT_W-1:0]    i_cfg_phase;
  logic                o_cfg_err;
  logic [CHANNELS-1:0] o_clk;
  logic                o_locked;
`ifdef CLKGEN_CE_EN
  logic [CHANNELS-1:0] o_ce;

  modport master (
    output i_cfg_we, i_cfg_ch, i_cfg_div, i_cfg_high, i_cfg_phase,
    input  o_cfg_err, o_clk, o_locked, o_ce
  );
  modport slave (
    input  i_cfg_we, i_cfg_ch, i_cfg_div, i_cfg_high, i_cfg_phase,
    output o_cfg_err, o_clk, o_locked, o_ce
  );
`else
  modport master (
    output i_cfg_we, i_cfg_ch, i_cfg_div, i_cfg_high, i_cfg_phase,
    input  o_cfg_err, o_clk, o_locked
  );
  modport slave (
    input  i_cfg_we, i_cfg_ch, i_cfg_div, i_cfg_high, i_cfg_phase,
    output o_cfg_err, o_clk, o_locked
  );
`endif

endinterface

// File: rtl/clk_gen_chan.sv
// One divided-clock channel.
// Ports: i_clk, i_rst (async, active-high), cfg (div/high/phase), align
// (load start count on this edge), gap (force output low on this edge),
// o_clk (registered waveform), o_ce (registered count-zero pulse, only when
// CLKGEN_CE_EN is defined).
module clk_gen_chan
  import clk_gen_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  chan_cfg_t cfg,
  input  logic      align,
  input  logic      gap,
  output logic      o_clk
`ifdef CLKGEN_CE_EN
  ,
  output logic      o_ce
`endif
);

  logic [CFG_W-1:0] cnt_q;
  logic [CFG_W-1:0] cnt_nxt_c;
  logic [CFG_W-1:0] start_c;

  // Next count: start value (t=0 is -phase mod div) on align, else wrap at div-1.
  always_comb begin
    start_c   = (cfg.phase == '0) ? '0 : (cfg.div - cfg.phase);
    cnt_nxt_c = cnt_q + CFG_W'(1);
    if (align) begin
      cnt_nxt_c = start_c;
    end else if (cnt_q >= (cfg.div - CFG_W'(1))) begin
      cnt_nxt_c = '0;
    end
  end

  // Output is derived from the count being loaded, so it lines up with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      o_clk <= 1'b0;
`ifdef CLKGEN_CE_EN
      o_ce  <= 1'b0;
`endif
    end else if (gap) begin
      o_clk <= 1'b0;
`ifdef CLKGEN_CE_EN
      o_ce  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_nxt_c;
      o_clk <= (cnt_nxt_c < cfg.high);
`ifdef CLKGEN_CE_EN
      o_ce  <= (cnt_nxt_c == '0);
`endif
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock-pattern generator: config registers, write check,
// realignment of all channels, lock counter and write-error pulse.
// Ports: i_clk, i_rst (async, active-high), bus (clk_gen_multi_if.slave:
// config write in, o_cfg_err / o_clk / o_locked out).
// Optional: CLKGEN_CE_EN adds bus.o_ce, a per-channel count-zero enable.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_W       = CFG_W,
  parameter int unsigned DEF_DIV     = DFLT_DIV,
  parameter int unsigned DEF_HIGH    = DFLT_HIGH,
  parameter int unsigned DEF_PHASE   = DFLT_PHASE,
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  clk_gen_multi_if.slave  bus
);

  localparam int unsigned LK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_CYCLES);
  localparam chan_cfg_t DEF_CFG = make_cfg(DEF_DIV, DEF_HIGH, DEF_PHASE);

  chan_cfg_t           cfg_q [CHANNELS];
  chan_cfg_t           wr_cfg_c;
  logic [CNT_W-1:0]    wr_div_c;
  logic [CNT_W-1:0]    wr_high_c;
  logic [CNT_W-1:0]    wr_phase_c;
  logic                wr_legal_c;
  logic                accept_c;
  logic                align_q;
  logic                err_q;
  logic                locked_q;
  logic [LK_W-1:0]     lock_cnt_q;
  logic [CHANNELS-1:0] clk_vec;

  // Write decode: channel in range and config self-consistent.
  always_comb begin
    wr_div_c       = bus.i_cfg_div;
    wr_high_c      = bus.i_cfg_high;
    wr_phase_c     = bus.i_cfg_phase;
    wr_cfg_c.div   = CFG_W'(wr_div_c);
    wr_cfg_c.high  = CFG_W'(wr_high_c);
    wr_cfg_c.phase = CFG_W'(wr_phase_c);
    wr_legal_c     = (32'(bus.i_cfg_ch) < CHANNELS) && cfg_legal(wr_cfg_c);
    accept_c       = bus.i_cfg_we && wr_legal_c;
  end

  // align_q resets high so the first edge after reset release is t=0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(CHANNELS); k++) cfg_q[k] <= DEF_CFG;
      align_q    <= 1'b1;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      err_q   <= bus.i_cfg_we && !wr_legal_c;
      align_q <= accept_c;
      if (accept_c) begin
        cfg_q[bus.i_cfg_ch] <= wr_cfg_c;
        lock_cnt_q          <= '0;
        locked_q            <= 1'b0;
      end else if (lock_cnt_q != LK_MAX) begin
        lock_cnt_q <= lock_cnt_q + LK_W'(1);
        locked_q   <= (lock_cnt_q == (LK_MAX - LK_W'(1)));
      end
    end
  end

`ifdef CLKGEN_CE_EN
  logic [CHANNELS-1:0] ce_vec;
  assign bus.o_ce = ce_vec;
`endif

  // Accepted write forces a gap on every channel; the next edge reloads all.
  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
    clk_gen_chan u_chan (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .cfg   (cfg_q[k]),
      .align (align_q),
      .gap   (accept_c),
      .o_clk (clk_vec[k])
`ifdef CLKGEN_CE_EN
      ,
      .o_ce  (ce_vec[k])
`endif
    );
  end

  assign bus.o_clk     = clk_vec;
  assign bus.o_cfg_err = err_q;
  assign bus.o_locked  = locked_q;

endmodule
